// File: rtl/multi_phase_traffic_controller_pkg.sv
// Shared types and the round-robin search helper for the multi-phase traffic controller.
package traffic_pkg;
    typedef enum logic [1:0] {CLEAR, GREEN, YELLOW, FLASH} state_t;
    typedef enum logic [1:0] {LAMP_OFF, LAMP_RED, LAMP_YELLOW, LAMP_GREEN} lamp_t;

    localparam int MAX_PHASES = 8;

    // First pending phase after cur (wrapping over n phases); falls back to 0 or cur.
    function automatic logic [2:0] next_phase(input logic [2:0] cur,
                                              input logic [MAX_PHASES-1:0] pend,
                                              input int n,
                                              input logic home);
        logic [2:0] res;
        logic       found;
        int         idx;
        res   = home ? 3'd0 : cur;
        found = 1'b0;
        for (int i = 1; i < MAX_PHASES; i++) begin
            idx = int'(cur) + i;
            if (idx >= n) idx = idx - n;
            if (!found && (i < n) && pend[idx[2:0]]) begin
                res   = idx[2:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction
endpackage

// File: rtl/multi_phase_traffic_controller_if.sv
// Request/lamp bundle between the controller and its environment.
interface multi_phase_traffic_controller_if #(
    parameter int NUM_PHASES = 4,
    parameter int TIME_W     = 6
);
    localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    logic                  tick_i;
    logic [TIME_W-1:0]     ShortTime_i;
    logic [TIME_W-1:0]     LongTime_i;
    logic [NUM_PHASES-1:0] req_i;
    logic                  flash_i;
    logic [NUM_PHASES-1:0] green_o;
    logic [NUM_PHASES-1:0] yellow_o;
    logic [NUM_PHASES-1:0] red_o;
    logic [PH_W-1:0]       phase_o;
    logic [NUM_PHASES-1:0] pending_o;

    modport master (
        output tick_i, ShortTime_i, LongTime_i, req_i, flash_i,
        input  green_o, yellow_o, red_o, phase_o, pending_o
    );

    modport slave (
        input  tick_i, ShortTime_i, LongTime_i, req_i, flash_i,
        output green_o, yellow_o, red_o, phase_o, pending_o
    );
endinterface

// File: rtl/multi_phase_traffic_controller_tlc_tick_timer.sv
// Tick-strobe down counter; a state loaded with D lasts exactly D ticks (D=0 behaves as 1).
module tlc_tick_timer #(
    parameter int                TIME_W    = 6,
    parameter logic [TIME_W-1:0] RESET_VAL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [TIME_W-1:0] i_value,
    input  logic              i_tick,
    output logic              o_expired
);
    localparam logic [TIME_W-1:0] ONE = TIME_W'(1);
    localparam logic [TIME_W-1:0] RST = (RESET_VAL == '0) ? ONE : RESET_VAL;

    logic [TIME_W-1:0] r_count;
    logic [TIME_W-1:0] w_load_val;

    assign w_load_val = (i_value == '0) ? ONE : i_value;
    assign o_expired  = i_tick && (r_count <= ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= RST;
        else if (i_load)
            r_count <= w_load_val;
        else if (i_tick && (r_count != '0))
            r_count <= r_count - ONE;
    end
endmodule

// File: rtl/multi_phase_traffic_controller.sv
// N-phase round-robin traffic light controller with all-red clearance, min-green,
// rest-in-green and flashing maintenance mode. Lamps are registered from the next-state decode.
module multi_phase_traffic_controller
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES  = 4,
    parameter int TIME_W      = 6,
    parameter int CLEAR_TICKS = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    multi_phase_traffic_controller_if.slave  bus
);
    localparam int                PH_W  = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam logic [TIME_W-1:0] CLR_T = TIME_W'(CLEAR_TICKS);

    state_t                r_state, w_next_state;
    logic [PH_W-1:0]       r_phase, w_next_phase;
    logic [NUM_PHASES-1:0] r_pending, w_next_pending;
    logic                  r_home, w_next_home;
    logic                  r_blink, w_next_blink;
    logic                  r_min_done, w_next_min_done;
    logic [NUM_PHASES-1:0] r_green, r_yellow, r_red;
    logic [NUM_PHASES-1:0] w_green, w_yellow, w_red;
    logic [NUM_PHASES-1:0] w_req_all, w_cur_mask, w_others, w_clr_mask;
    logic [PH_W-1:0]       w_search;
    logic                  w_load, w_expired;
    logic [TIME_W-1:0]     w_load_val;

    tlc_tick_timer #(.TIME_W(TIME_W), .RESET_VAL(CLR_T)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_value   (w_load_val),
        .i_tick    (bus.tick_i),
        .o_expired (w_expired)
    );

    assign w_req_all  = r_pending | bus.req_i;
    assign w_cur_mask = NUM_PHASES'(1) << r_phase;
    assign w_others   = w_req_all & ~w_cur_mask;
    assign w_search   = PH_W'(next_phase(3'(r_phase), MAX_PHASES'(w_req_all), NUM_PHASES, r_home));

    always_comb begin
        w_next_state    = r_state;
        w_next_phase    = r_phase;
        w_next_home     = r_home;
        w_next_blink    = r_blink;
        w_next_min_done = r_min_done;
        w_load          = 1'b0;
        w_load_val      = '0;
        unique case (r_state)
            CLEAR: if (w_expired) begin
                w_load = 1'b1;
                if (bus.flash_i) begin
                    w_next_state = FLASH;
                    w_next_blink = 1'b1;
                end else begin
                    w_next_state    = GREEN;
                    w_next_phase    = w_search;
                    w_next_home     = 1'b0;
                    w_next_min_done = 1'b0;
                    w_load_val      = bus.LongTime_i;
                end
            end
            GREEN: begin
                if (w_expired) w_next_min_done = 1'b1;
                // A request on the expiring tick counts immediately; flash skips min-green.
                if (bus.flash_i || ((w_expired || r_min_done) && (|w_others))) begin
                    w_next_state = YELLOW;
                    w_load       = 1'b1;
                    w_load_val   = bus.ShortTime_i;
                end
            end
            YELLOW: if (w_expired) begin
                w_next_state = CLEAR;
                w_load       = 1'b1;
                w_load_val   = CLR_T;
            end
            FLASH: if (bus.tick_i) begin
                if (!bus.flash_i) begin
                    w_next_state = CLEAR;
                    w_next_home  = 1'b1;
                    w_next_blink = 1'b0;
                    w_load       = 1'b1;
                    w_load_val   = CLR_T;
                end else begin
                    w_next_blink = ~r_blink;
                end
            end
            default: w_next_state = CLEAR;
        endcase
    end

    // Requests for the phase holding (or taking) green are dropped.
    always_comb begin
        w_clr_mask = '0;
        if (r_state == GREEN)      w_clr_mask = w_clr_mask | w_cur_mask;
        if (w_next_state == GREEN) w_clr_mask = w_clr_mask | (NUM_PHASES'(1) << w_next_phase);
        w_next_pending = w_req_all & ~w_clr_mask;
    end

    always_comb begin
        w_green  = '0;
        w_yellow = '0;
        w_red    = '0;
        for (int k = 0; k < NUM_PHASES; k++) begin
            lamp_t w_lamp;
            w_lamp = LAMP_RED;
            unique case (w_next_state)
                GREEN:   if (PH_W'(k) == w_next_phase) w_lamp = LAMP_GREEN;
                YELLOW:  if (PH_W'(k) == w_next_phase) w_lamp = LAMP_YELLOW;
                FLASH:   w_lamp = !w_next_blink ? LAMP_OFF : ((k == 0) ? LAMP_YELLOW : LAMP_RED);
                default: w_lamp = LAMP_RED;
            endcase
            w_green[k]  = (w_lamp == LAMP_GREEN);
            w_yellow[k] = (w_lamp == LAMP_YELLOW);
            w_red[k]    = (w_lamp == LAMP_RED);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CLEAR;
            r_phase    <= '0;
            r_pending  <= '0;
            r_home     <= 1'b1;
            r_blink    <= 1'b0;
            r_min_done <= 1'b0;
            r_green    <= '0;
            r_yellow   <= '0;
            r_red      <= '1;
        end else begin
            r_state    <= w_next_state;
            r_phase    <= w_next_phase;
            r_pending  <= w_next_pending;
            r_home     <= w_next_home;
            r_blink    <= w_next_blink;
            r_min_done <= w_next_min_done;
            r_green    <= w_green;
            r_yellow   <= w_yellow;
            r_red      <= w_red;
        end
    end

    assign bus.green_o   = r_green;
    assign bus.yellow_o  = r_yellow;
    assign bus.red_o     = r_red;
    assign bus.phase_o   = r_phase;
    assign bus.pending_o = r_pending;
endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
// Directed bench for the multi-phase traffic controller (N=4, Long=5, Short=3, clear=2).
module tb_multi_phase_traffic_controller;
    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;

    // Lamp patterns as {green, yellow, red}
    localparam logic [11:0] ALLRED = {4'b0000, 4'b0000, 4'b1111};
    localparam logic [11:0] G0     = {4'b0001, 4'b0000, 4'b1110};
    localparam logic [11:0] G1     = {4'b0010, 4'b0000, 4'b1101};
    localparam logic [11:0] G2     = {4'b0100, 4'b0000, 4'b1011};
    localparam logic [11:0] G3     = {4'b1000, 4'b0000, 4'b0111};
    localparam logic [11:0] Y0     = {4'b0000, 4'b0001, 4'b1110};
    localparam logic [11:0] Y1     = {4'b0000, 4'b0010, 4'b1101};
    localparam logic [11:0] FON    = {4'b0000, 4'b0001, 4'b1110};
    localparam logic [11:0] FOFF   = 12'h000;

    multi_phase_traffic_controller_if #(.NUM_PHASES(4), .TIME_W(6)) bus ();

    multi_phase_traffic_controller #(.NUM_PHASES(4), .TIME_W(6), .CLEAR_TICKS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] lamps();
        return {bus.green_o, bus.yellow_o, bus.red_o};
    endfunction

    task automatic inv_check();
        logic [3:0] g, y, r;
        g = bus.green_o; y = bus.yellow_o; r = bus.red_o;
        vectors++;
        if ((((g & y) | (g & r) | (y & r)) != 4'b0) ||
            (((g | y | r) != 4'b0) && (((g | y | r) != 4'hF) || ($countones(~r) > 1)))) begin
            errors++;
            $display("FAIL invariant g=%b y=%b r=%b", g, y, r);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk); bus.tick_i = 1'b1;
            @(negedge clk); bus.tick_i = 1'b0;
            inv_check();
        end
    endtask

    task automatic tick_req(input logic [3:0] r);
        @(negedge clk); bus.tick_i = 1'b1; bus.req_i = r;
        @(negedge clk); bus.tick_i = 1'b0; bus.req_i = 4'b0;
        inv_check();
    endtask

    task automatic pulse_req(input logic [3:0] r);
        @(negedge clk); bus.req_i = r;
        @(negedge clk); bus.req_i = 4'b0;
        inv_check();
    endtask

    task automatic do_reset();
        bus.tick_i = 1'b0; bus.req_i = 4'b0; bus.flash_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (lamps() !== ALLRED || bus.phase_o !== 2'd0 || bus.pending_o !== 4'b0) begin
            errors++;
            $display("FAIL reset_state lamps=%h phase=%0d pend=%b want lamps=%h phase=0 pend=0000",
                     lamps(), bus.phase_o, bus.pending_o, ALLRED);
        end
        ticks(1);
        vectors++;
        if (lamps() !== ALLRED) begin errors++; $display("FAIL reset_clear1 got %h want %h", lamps(), ALLRED); end
        ticks(1);
        vectors++;
        if (lamps() !== G0) begin errors++; $display("FAIL reset_green got %h want %h", lamps(), G0); end
        ticks(10);
        vectors++;
        if (lamps() !== G0) begin errors++; $display("FAIL reset_rest got %h want %h", lamps(), G0); end
    endtask

    task automatic test_request();
        do_reset();
        ticks(2);
        tick_req(4'b0100);
        vectors++;
        if (lamps() !== G0 || bus.pending_o !== 4'b0100) begin
            errors++;
            $display("FAIL req_latch lamps=%h pend=%b want %h 0100", lamps(), bus.pending_o, G0);
        end
        ticks(3);
        vectors++;
        if (lamps() !== G0) begin errors++; $display("FAIL req_mingreen got %h want %h", lamps(), G0); end
        ticks(1);
        vectors++;
        if (lamps() !== Y0) begin errors++; $display("FAIL req_yellow got %h want %h", lamps(), Y0); end
        ticks(2);
        vectors++;
        if (lamps() !== Y0) begin errors++; $display("FAIL req_yellow3 got %h want %h", lamps(), Y0); end
        ticks(1);
        vectors++;
        if (lamps() !== ALLRED) begin errors++; $display("FAIL req_clear got %h want %h", lamps(), ALLRED); end
        ticks(1);
        vectors++;
        if (lamps() !== ALLRED) begin errors++; $display("FAIL req_clear2 got %h want %h", lamps(), ALLRED); end
        ticks(1);
        vectors++;
        if (lamps() !== G2 || bus.phase_o !== 2'd2 || bus.pending_o !== 4'b0) begin
            errors++;
            $display("FAIL req_green2 lamps=%h phase=%0d pend=%b want %h 2 0000",
                     lamps(), bus.phase_o, bus.pending_o, G2);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        ticks(7);
        vectors++;
        if (lamps() !== G0) begin errors++; $display("FAIL rr_rest got %h want %h", lamps(), G0); end
        pulse_req(4'b1010);
        vectors++;
        if (lamps() !== Y0 || bus.pending_o !== 4'b1010) begin
            errors++;
            $display("FAIL rr_yellow lamps=%h pend=%b want %h 1010", lamps(), bus.pending_o, Y0);
        end
        ticks(5);
        vectors++;
        if (lamps() !== G1 || bus.phase_o !== 2'd1 || bus.pending_o !== 4'b1000) begin
            errors++;
            $display("FAIL rr_green1 lamps=%h phase=%0d pend=%b want %h 1 1000",
                     lamps(), bus.phase_o, bus.pending_o, G1);
        end
        ticks(4);
        vectors++;
        if (lamps() !== G1) begin errors++; $display("FAIL rr_hold1 got %h want %h", lamps(), G1); end
        ticks(1);
        vectors++;
        if (lamps() !== Y1) begin errors++; $display("FAIL rr_yellow1 got %h want %h", lamps(), Y1); end
        ticks(5);
        vectors++;
        if (lamps() !== G3 || bus.phase_o !== 2'd3 || bus.pending_o !== 4'b0) begin
            errors++;
            $display("FAIL rr_green3 lamps=%h phase=%0d pend=%b want %h 3 0000",
                     lamps(), bus.phase_o, bus.pending_o, G3);
        end
        ticks(10);
        vectors++;
        if (lamps() !== G3) begin errors++; $display("FAIL rr_rest3 got %h want %h", lamps(), G3); end
    endtask

    task automatic test_flash();
        do_reset();
        ticks(3);
        @(negedge clk); bus.tick_i = 1'b1; bus.flash_i = 1'b1;
        @(negedge clk); bus.tick_i = 1'b0;
        vectors++;
        if (lamps() !== Y0) begin errors++; $display("FAIL flash_abort got %h want %h", lamps(), Y0); end
        ticks(2);
        vectors++;
        if (lamps() !== Y0) begin errors++; $display("FAIL flash_yellow got %h want %h", lamps(), Y0); end
        ticks(2);
        vectors++;
        if (lamps() !== ALLRED) begin errors++; $display("FAIL flash_clear got %h want %h", lamps(), ALLRED); end
        ticks(1);
        vectors++;
        if (lamps() !== FON) begin errors++; $display("FAIL flash_on got %h want %h", lamps(), FON); end
        ticks(1);
        vectors++;
        if (lamps() !== FOFF) begin errors++; $display("FAIL flash_off got %h want %h", lamps(), FOFF); end
        ticks(1);
        vectors++;
        if (lamps() !== FON) begin errors++; $display("FAIL flash_on2 got %h want %h", lamps(), FON); end
        @(negedge clk); bus.flash_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (lamps() !== FON) begin errors++; $display("FAIL flash_waittick got %h want %h", lamps(), FON); end
        ticks(1);
        vectors++;
        if (lamps() !== ALLRED) begin errors++; $display("FAIL flash_exit got %h want %h", lamps(), ALLRED); end
        ticks(2);
        vectors++;
        if (lamps() !== G0 || bus.phase_o !== 2'd0) begin
            errors++;
            $display("FAIL flash_green0 lamps=%h phase=%0d want %h 0", lamps(), bus.phase_o, G0);
        end
    endtask

    task automatic test_zero_times();
        bus.LongTime_i = 6'd0; bus.ShortTime_i = 6'd0;
        do_reset();
        ticks(2);
        pulse_req(4'b0010);
        vectors++;
        if (lamps() !== G0 || bus.pending_o !== 4'b0010) begin
            errors++;
            $display("FAIL zero_hold lamps=%h pend=%b want %h 0010", lamps(), bus.pending_o, G0);
        end
        ticks(1);
        vectors++;
        if (lamps() !== Y0) begin errors++; $display("FAIL zero_yellow got %h want %h", lamps(), Y0); end
        ticks(1);
        vectors++;
        if (lamps() !== ALLRED) begin errors++; $display("FAIL zero_clear got %h want %h", lamps(), ALLRED); end
        ticks(2);
        vectors++;
        if (lamps() !== G1) begin errors++; $display("FAIL zero_green1 got %h want %h", lamps(), G1); end
        bus.LongTime_i = 6'd5; bus.ShortTime_i = 6'd3;
    endtask

    task automatic test_mid_change();
        bus.LongTime_i = 6'd3;
        do_reset();
        ticks(2);
        tick_req(4'b0100);
        bus.LongTime_i = 6'd20;
        ticks(1);
        vectors++;
        if (lamps() !== G0) begin errors++; $display("FAIL mid_hold got %h want %h", lamps(), G0); end
        ticks(1);
        vectors++;
        if (lamps() !== Y0) begin errors++; $display("FAIL mid_yellow got %h want %h", lamps(), Y0); end
        bus.LongTime_i = 6'd5;
    endtask

    task automatic test_async_reset();
        do_reset();
        ticks(2);
        tick_req(4'b0010);
        ticks(4);
        vectors++;
        if (lamps() !== Y0) begin errors++; $display("FAIL ar_yellow got %h want %h", lamps(), Y0); end
        ticks(1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (lamps() !== ALLRED || bus.pending_o !== 4'b0 || bus.phase_o !== 2'd0) begin
            errors++;
            $display("FAIL ar_immediate lamps=%h pend=%b phase=%0d want %h 0000 0",
                     lamps(), bus.pending_o, bus.phase_o, ALLRED);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        ticks(2);
        vectors++;
        if (lamps() !== G0) begin errors++; $display("FAIL ar_green0 got %h want %h", lamps(), G0); end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        bus.tick_i = 1'b0; bus.req_i = 4'b0; bus.flash_i = 1'b0;
        bus.LongTime_i = 6'd5; bus.ShortTime_i = 6'd3;
        test_reset();
        test_request();
        test_round_robin();
        test_flash();
        test_zero_times();
        test_mid_change();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
